// File: rtl/systolic_tile_controller.sv
// Tile sequencer for a ROWS x COLS systolic array: clear, feed, flush and drain per output tile.
// Define SYSTOLIC_CTRL_PERF_EN to build the busy-cycle and stall performance counters.
module systolic_tile_controller #(
    parameter int unsigned ROWS   = 4,
    parameter int unsigned COLS   = 4,
    parameter int unsigned K_MAX  = 16,
    parameter int unsigned TILE_W = 8,
    parameter int unsigned KW     = $clog2(K_MAX + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [KW-1:0]           k_len,
    input  logic [TILE_W-1:0]       num_tiles,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic                    valid_src,
    output logic                    clear_acc,
    output logic [KW-1:0]           k_idx,
    output logic [TILE_W-1:0]       tile_idx,
    output logic                    drain_valid,
    output logic [$clog2(ROWS)-1:0] drain_row,
    input  logic                    out_ready,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [31:0]             stall_cnt,
    output logic [31:0]             cycle_cnt
);
    localparam int unsigned F  = ROWS + COLS - 2;
    localparam int unsigned FW = $clog2(F + 1);
    localparam int unsigned RW = $clog2(ROWS);

    typedef enum logic [2:0] {StIdle, StClear, StFeed, StFlush, StDrain, StDone} state_e;

    state_e            state_q;
    logic [KW-1:0]     k_len_q;
    logic [KW-1:0]     k_idx_q;
    logic [TILE_W-1:0] num_tiles_q;
    logic [TILE_W-1:0] tile_idx_q;
    logic [FW-1:0]     flush_q;
    logic [RW-1:0]     drain_row_q;
    logic              err_q;
    logic              cmd_ok;
    logic              accept;

    assign cmd_ok = (k_len != '0) && (k_len <= KW'(K_MAX)) && (num_tiles != '0);
    assign accept = (state_q == StIdle) && start && cmd_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            k_len_q     <= '0;
            k_idx_q     <= '0;
            num_tiles_q <= '0;
            tile_idx_q  <= '0;
            flush_q     <= '0;
            drain_row_q <= '0;
            err_q       <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        k_len_q     <= k_len;
                        num_tiles_q <= num_tiles;
                        tile_idx_q  <= '0;
                        state_q     <= StClear;
                    end else if (start) begin
                        err_q <= 1'b1;
                    end
                end
                StClear: begin
                    k_idx_q <= '0;
                    state_q <= StFeed;
                end
                StFeed: begin
                    if (in_valid) begin
                        k_idx_q <= k_idx_q + KW'(1);
                        if (k_idx_q == k_len_q - KW'(1)) begin
                            flush_q <= '0;
                            state_q <= StFlush;
                        end
                    end
                end
                StFlush: begin
                    // Let the last operand wave propagate across the array diagonal.
                    if (flush_q == FW'(F - 1)) begin
                        drain_row_q <= '0;
                        state_q     <= StDrain;
                    end else begin
                        flush_q <= flush_q + FW'(1);
                    end
                end
                StDrain: begin
                    if (out_ready) begin
                        if (drain_row_q == RW'(ROWS - 1)) begin
                            if (tile_idx_q == num_tiles_q - TILE_W'(1)) begin
                                state_q <= StDone;
                            end else begin
                                tile_idx_q <= tile_idx_q + TILE_W'(1);
                                state_q    <= StClear;
                            end
                        end else begin
                            drain_row_q <= drain_row_q + RW'(1);
                        end
                    end
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_ready    = (state_q == StFeed);
    assign valid_src   = in_valid && in_ready;
    assign clear_acc   = (state_q == StClear);
    assign drain_valid = (state_q == StDrain);
    assign done        = (state_q == StDone);
    assign busy        = (state_q != StIdle) && (state_q != StDone);
    assign err         = err_q;
    assign k_idx       = k_idx_q;
    assign tile_idx    = tile_idx_q;
    assign drain_row   = drain_row_q;

`ifdef SYSTOLIC_CTRL_PERF_EN
    logic [31:0] cycle_cnt_q;
    logic [31:0] stall_cnt_q;
    logic        stall_now;

    assign stall_now = ((state_q == StFeed) && !in_valid) || ((state_q == StDrain) && !out_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else if (accept) begin
            cycle_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (busy && (cycle_cnt_q != '1)) begin
                cycle_cnt_q <= cycle_cnt_q + 32'd1;
            end
            if (stall_now && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign cycle_cnt = cycle_cnt_q;
    assign stall_cnt = stall_cnt_q;
`else
    assign cycle_cnt = '0;
    assign stall_cnt = '0;
`endif

endmodule
